// File: rtl/reverb_pio_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : reverb_pio_pkg                                               |
// | Description : Shared register map, edge-type encoding and bus width for    |
// |               the reverb system PIO blocks.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package reverb_pio_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK    = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

endpackage

`default_nettype wire

// File: rtl/reverb_pio_edge_det.sv
// +----------------------------------------------------------------------------+
// | Module      : reverb_pio_edge_det                                          |
// | Description : Input sample stage, optional two-flop synchronizer           |
// |               (REVERB_PIO_IN_SYNC_EN), priming and edge select.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module reverb_pio_edge_det
    import reverb_pio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] ev
);

    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_p;
    logic             r_primed;
    logic [WIDTH-1:0] w_s_next;
    logic             w_fill_done;
    logic [WIDTH-1:0] w_sel;

`ifdef REVERB_PIO_IN_SYNC_EN
    logic [WIDTH-1:0] r_sync;
    logic             r_fill;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_fill <= 1'b0;
        end else begin
            r_sync <= in_port;
            r_fill <= 1'b1;
        end
    end

    assign w_s_next    = r_sync;
    assign w_fill_done = r_fill;
`else
    assign w_s_next    = in_port;
    assign w_fill_done = 1'b1;
`endif

    // Until primed, p follows the value entering s so a level already present
    // at reset release is taken as the baseline rather than an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s      <= '0;
            r_p      <= '0;
            r_primed <= 1'b0;
        end else begin
            r_s      <= w_s_next;
            r_p      <= r_primed ? r_s : w_s_next;
            r_primed <= w_fill_done;
        end
    end

    always_comb begin
        w_sel = r_s ^ r_p;
        case (EDGE_TYPE)
            int'(EDGE_RISE): w_sel = r_s & ~r_p;
            int'(EDGE_FALL): w_sel = ~r_s & r_p;
            default:         w_sel = r_s ^ r_p;
        endcase
    end

    assign s  = r_s;
    assign ev = r_primed ? w_sel : '0;

endmodule

`default_nettype wire

// File: rtl/reverb_pio_in_edge.sv
// +----------------------------------------------------------------------------+
// | Module      : reverb_pio_in_edge                                           |
// | Description : Avalon-MM input PIO with sticky edge capture and level irq.  |
// |               Define REVERB_PIO_IN_SYNC_EN for a two-flop input sync.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module reverb_pio_in_edge
    import reverb_pio_pkg::*;
#(
    parameter int          WIDTH          = 8,
    parameter int          EDGE_TYPE      = 0,
    parameter logic [31:0] IRQ_MASK_RESET = 32'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq,
    input  logic [WIDTH-1:0]  in_port
);

    localparam logic [DATA_W-1:0] c_WMASK = {DATA_W{1'b1}} >> (DATA_W - WIDTH);

    logic [WIDTH-1:0]  w_s;
    logic [WIDTH-1:0]  w_ev;
    logic [DATA_W-1:0] w_s32;
    logic [DATA_W-1:0] w_ev32;
    logic [DATA_W-1:0] w_clr;
    logic [DATA_W-1:0] w_cap_next;
    logic [DATA_W-1:0] w_mask_next;
    logic              w_wr;
    logic              w_rd;

    logic [DATA_W-1:0] r_cap;
    logic [DATA_W-1:0] r_mask;
    logic [DATA_W-1:0] r_readdata;
    logic              r_irq;

    reverb_pio_edge_det #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_edge_det (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .s       (w_s),
        .ev      (w_ev)
    );

    assign w_s32  = DATA_W'(w_s);
    assign w_ev32 = DATA_W'(w_ev);
    assign w_wr   = chipselect & ~write_n;
    assign w_rd   = chipselect & ~read_n;

    // Capture and mask bits above WIDTH are held at zero by c_WMASK.
    always_comb begin
        w_clr       = '0;
        w_mask_next = r_mask;
        if (w_wr && (address == PIO_ADDR_EDGECAP)) begin
            w_clr = writedata & c_WMASK;
        end
        if (w_wr && (address == PIO_ADDR_MASK)) begin
            w_mask_next = writedata & c_WMASK;
        end
        w_cap_next = w_ev32 | (r_cap & ~w_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap      <= '0;
            r_mask     <= IRQ_MASK_RESET & c_WMASK;
            r_irq      <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_cap  <= w_cap_next;
            r_mask <= w_mask_next;
            r_irq  <= |(w_cap_next & w_mask_next);
            if (w_rd) begin
                case (address)
                    PIO_ADDR_DATA:    r_readdata <= w_s32;
                    PIO_ADDR_MASK:    r_readdata <= r_mask;
                    PIO_ADDR_EDGECAP: r_readdata <= r_cap;
                    default:          r_readdata <= '0;
                endcase
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_reverb_pio_in_edge.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_reverb_pio_in_edge                                        |
// | Description : Bench for reverb_pio_in_edge, three edge types in parallel.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_reverb_pio_in_edge;

`ifdef REVERB_PIO_IN_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rdata [3];
    logic        irqv  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reverb_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_MASK_RESET(32'h00)) dut_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rdata[0]), .irq(irqv[0]), .in_port(in_port));

    reverb_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(1), .IRQ_MASK_RESET(32'h00)) dut_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rdata[1]), .irq(irqv[1]), .in_port(in_port));

    reverb_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(2), .IRQ_MASK_RESET(32'h5A)) dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rdata[2]), .irq(irqv[2]), .in_port(in_port));

    // Reference model: the sample stream seen by each DUT is in_port delayed by
    // D clocks; a captured event is any selected transition between two
    // consecutive post-reset samples.
    logic [7:0]  m_cap  [3];
    logic [7:0]  m_mask [3];
    logic        m_irq  [3];
    logic [31:0] m_rd   [3];
    logic [7:0]  hist   [3];
    int          nsamp;
    int          et [3] = '{0, 1, 2};
    logic [7:0]  mr [3] = '{8'h00, 8'h00, 8'h5A};

    always @(posedge clk) begin
        logic [7:0] sc, pc, evm, clr;
        if (reset) begin
            nsamp = 0;
            for (int i = 0; i < 3; i++) hist[i] = 8'h00;
            for (int k = 0; k < 3; k++) begin
                m_cap[k] = 8'h00; m_mask[k] = mr[k]; m_irq[k] = 1'b0; m_rd[k] = 32'h0;
            end
        end else begin
            sc = (nsamp >= D) ? hist[D-1] : 8'h00;
            pc = (nsamp >= D + 1) ? hist[D] : 8'h00;
            for (int k = 0; k < 3; k++) begin
                if (nsamp < D + 1) evm = 8'h00;
                else if (et[k] == 0) evm = sc & ~pc;
                else if (et[k] == 1) evm = ~sc & pc;
                else evm = sc ^ pc;
                if (chipselect && !read_n) begin
                    case (address)
                        2'd0: m_rd[k] = {24'h0, sc};
                        2'd2: m_rd[k] = {24'h0, m_mask[k]};
                        2'd3: m_rd[k] = {24'h0, m_cap[k]};
                        default: m_rd[k] = 32'h0;
                    endcase
                end
                clr = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
                if (chipselect && !write_n && address == 2'd2) m_mask[k] = writedata[7:0];
                m_cap[k] = evm | (m_cap[k] & ~clr);
                m_irq[k] = |(m_cap[k] & m_mask[k]);
            end
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = in_port;
            if (nsamp < 8) nsamp = nsamp + 1;
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; address = 2'd0; writedata = 32'h0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1; address = a; writedata = d;
        cyc();
        idle();
    endtask

    task automatic rd(input logic [1:0] a);
        chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1; address = a;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        idle();
        in_port = 8'hFF;
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        repeat (5) cyc();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (irqv[k] !== 1'b0) begin errors++; $display("FAIL reset_irq dut%0d: got %b want 0", k, irqv[k]); end
        end
        rd(2'd3);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdata[k] !== 32'h0) begin errors++; $display("FAIL reset_edgecap dut%0d: got %h want 0", k, rdata[k]); end
        end
        rd(2'd0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdata[k] !== 32'hFF) begin errors++; $display("FAIL reset_data dut%0d: got %h want ff", k, rdata[k]); end
        end
        rd(2'd2);
        checks++;
        if (rdata[2] !== 32'h5A) begin errors++; $display("FAIL reset_mask dut2: got %h want 5a", rdata[2]); end
    endtask

    task automatic test_rise_irq();
        in_port = 8'h00;
        repeat (5) cyc();
        wr(2'd3, 32'hFF);
        wr(2'd2, 32'h01);
        in_port[0] = 1'b1;
        repeat (D) cyc();
        checks++;
        if (irqv[0] !== 1'b0) begin errors++; $display("FAIL rise_early dut0: got %b want 0", irqv[0]); end
        cyc();
        checks++;
        if (irqv[0] !== 1'b1) begin errors++; $display("FAIL rise_irq dut0: got %b want 1", irqv[0]); end
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (irqv[k] !== m_irq[k]) begin errors++; $display("FAIL rise_irq_model dut%0d: got %b want %b", k, irqv[k], m_irq[k]); end
        end
        rd(2'd3);
        checks++;
        if (rdata[0] !== 32'h01) begin errors++; $display("FAIL rise_cap dut0: got %h want 01", rdata[0]); end
        wr(2'd3, 32'h01);
        checks++;
        if (irqv[0] !== 1'b0) begin errors++; $display("FAIL w1c_irq dut0: got %b want 0", irqv[0]); end
        rd(2'd3);
        checks++;
        if (rdata[0] !== 32'h00) begin errors++; $display("FAIL w1c_cap dut0: got %h want 00", rdata[0]); end
    endtask

    task automatic test_masked();
        wr(2'd2, 32'h00);
        in_port[3] = 1'b1;
        repeat (D + 2) cyc();
        rd(2'd3);
        checks++;
        if (rdata[0] !== 32'h08) begin errors++; $display("FAIL masked_cap dut0: got %h want 08", rdata[0]); end
        checks++;
        if (irqv[0] !== 1'b0) begin errors++; $display("FAIL masked_irq dut0: got %b want 0", irqv[0]); end
        wr(2'd2, 32'h08);
        checks++;
        if (irqv[0] !== 1'b1) begin errors++; $display("FAIL unmask_irq dut0: got %b want 1", irqv[0]); end
    endtask

    task automatic test_set_wins();
        in_port[2] = 1'b1;
        repeat (D) cyc();
        wr(2'd3, 32'h04);
        rd(2'd3);
        checks++;
        if (rdata[0] !== 32'h0C) begin errors++; $display("FAIL set_wins dut0: got %h want 0c", rdata[0]); end
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (rdata[k] !== m_rd[k]) begin errors++; $display("FAIL set_wins_model dut%0d: got %h want %h", k, rdata[k], m_rd[k]); end
        end
    endtask

    task automatic test_any_toggle();
        in_port[5] = 1'b1;
        repeat (D + 2) cyc();
        wr(2'd3, 32'hFF);
        in_port[5] = 1'b0;
        repeat (D + 2) cyc();
        rd(2'd3);
        checks++;
        if (rdata[2] !== 32'h20) begin errors++; $display("FAIL any_fall dut2: got %h want 20", rdata[2]); end
        wr(2'd3, 32'h20);
        in_port[5] = 1'b1;
        repeat (D + 2) cyc();
        rd(2'd3);
        checks++;
        if (rdata[2] !== 32'h20) begin errors++; $display("FAIL any_rise dut2: got %h want 20", rdata[2]); end
        checks++;
        if (rdata[0] !== 32'h20) begin errors++; $display("FAIL rise_after_clear dut0: got %h want 20", rdata[0]); end
    endtask

    task automatic test_read_latency();
        rd(2'd1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdata[k] !== 32'h0) begin errors++; $display("FAIL reserved_read dut%0d: got %h want 0", k, rdata[k]); end
        end
        rd(2'd3);
        chipselect = 1'b1; read_n = 1'b0; address = 2'd0;
        #1;
        checks++;
        if (rdata[2] !== 32'h20) begin errors++; $display("FAIL read_hold_pre dut2: got %h want 20", rdata[2]); end
        cyc();
        idle();
        checks++;
        if (rdata[0] !== {24'h0, in_port}) begin errors++; $display("FAIL read_lat1 dut0: got %h want %h", rdata[0], in_port); end
        cyc();
        checks++;
        if (rdata[0] !== {24'h0, in_port}) begin errors++; $display("FAIL read_hold dut0: got %h want %h", rdata[0], in_port); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 79) == 0);
            chipselect = $urandom_range(0, 1);
            read_n     = $urandom_range(0, 1);
            write_n    = $urandom_range(0, 1);
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            if ($urandom_range(0, 2) == 0) in_port = in_port ^ (8'h01 << $urandom_range(0, 7));
            cyc();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rdata[k] !== m_rd[k]) begin errors++; $display("FAIL rand_rdata dut%0d cyc%0d: got %h want %h", k, n, rdata[k], m_rd[k]); end
                checks++;
                if (irqv[k] !== m_irq[k]) begin errors++; $display("FAIL rand_irq dut%0d cyc%0d: got %b want %b", k, n, irqv[k], m_irq[k]); end
            end
        end
        reset = 1'b0;
        idle();
        cyc();
    endtask

    task automatic test_reset_mid();
        in_port = 8'h00;
        repeat (5) cyc();
        wr(2'd3, 32'hFF);
        wr(2'd2, 32'hFF);
        in_port = 8'hFF;
        repeat (D + 2) cyc();
        rd(2'd3);
        checks++;
        if (rdata[0] !== 32'hFF) begin errors++; $display("FAIL pre_reset_cap dut0: got %h want ff", rdata[0]); end
        checks++;
        if (irqv[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_irq dut0: got %b want 1", irqv[0]); end
        reset = 1'b1;
        chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0; address = 2'd2; writedata = 32'h3C;
        cyc();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (irqv[k] !== 1'b0) begin errors++; $display("FAIL mid_reset_irq dut%0d: got %b want 0", k, irqv[k]); end
            checks++;
            if (rdata[k] !== 32'h0) begin errors++; $display("FAIL mid_reset_rdata dut%0d: got %h want 0", k, rdata[k]); end
        end
        idle();
        reset = 1'b0;
        cyc();
        rd(2'd2);
        checks++;
        if (rdata[0] !== 32'h00) begin errors++; $display("FAIL mask_reset dut0: got %h want 00", rdata[0]); end
        checks++;
        if (rdata[2] !== 32'h5A) begin errors++; $display("FAIL mask_reset dut2: got %h want 5a", rdata[2]); end
        rd(2'd3);
        checks++;
        if (rdata[0] !== 32'h00) begin errors++; $display("FAIL post_reset_cap dut0: got %h want 00", rdata[0]); end
    endtask

    initial begin
        reset = 1'b1;
        in_port = 8'h00;
        idle();
        test_reset();
        test_rise_irq();
        test_masked();
        test_set_wins();
        test_any_toggle();
        test_read_latency();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reverb_pio_in_edge.md
# reverb_pio_in_edge

Avalon-MM slave input PIO with edge capture and interrupt: the CPU-readable counterpart to the reverb system's output PIOs. It samples a WIDTH-bit status/strobe bus from the audio datapath (e.g. frame-done, overflow, button), latches selected edges into a sticky capture register, and raises a level interrupt to the Nios II core for unmasked captured bits.

## Interface
Parameters:
- WIDTH, 8, number of input bits (1..32).
- EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any.
- IRQ_MASK_RESET, 0, reset value of the irq mask register.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register word address.
- chipselect  in  1  slave select.
- read_n  in  1  active-low read strobe.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH ignored.
- readdata  out  32  registered read data, zero-extended above WIDTH.
- irq  out  1  level interrupt, registered.
- in_port  in  WIDTH  asynchronous input bus from the datapath.

## Operation
- Register map: addr 0 DATA (RO, current sample s), addr 1 reserved (reads 0, writes ignored), addr 2 IRQMASK (RW), addr 3 EDGECAP (R, write-1-to-clear per bit).
- Sample path: s = in_port after the synchronizer (see Configuration); p = s delayed one cycle.
- Edge detect per bit: rise = s & ~p, fall = ~s & p; ev selected by EDGE_TYPE.
- Priming: one-bit flag primed cleared by reset, set on the first cycle after reset; ev forced 0 while primed=0, so an input held high through reset never registers as an edge.
- EDGECAP[i] next = ev[i] | (EDGECAP[i] & ~clr[i]), where clr = writedata on a write to addr 3. Set wins over a same-cycle clear: no lost events.
- Write to addr 2 loads IRQMASK[WIDTH-1:0]; writes to addr 0/1 are ignored.
- irq next = |(EDGECAP_next & IRQMASK_next), registered.
- Read and write in the same cycle: write takes effect; read returns the pre-write value.

## Timing
- Reset values: readdata 0, irq 0, EDGECAP 0, IRQMASK IRQ_MASK_RESET, s/p/sync flops 0, primed 0.
- Read latency 1: readdata is valid on the edge after chipselect & ~read_n; it holds until the next read. No waitrequest.
- in_port to s: 1 cycle without the macro, 2 cycles with it.
- s edge to EDGECAP bit set: 1 cycle (p compares against s in the same cycle).
- EDGECAP set to irq high: same edge; irq is a function of next-state values.
- Write-1-clear of the last unmasked bit: irq low on the edge that performs the write.
- Reset asserted mid-operation clears all state on the next edge regardless of bus activity. Edges occurring in the first cycle after reset release are dropped.

## Configuration
- REVERB_PIO_IN_SYNC_EN defined: two-flop synchronizer on in_port (for inputs from other clock domains); total in_port-to-EDGECAP latency 3 cycles.
- Not defined: a single register stage (inputs already in clk domain); latency 2 cycles. The register map and irq behaviour are otherwise identical.

## Structure
- Shared package reverb_pio_pkg: address constants (PIO_ADDR_DATA=0, PIO_ADDR_MASK=2, PIO_ADDR_EDGECAP=3), edge type enum (EDGE_RISE, EDGE_FALL, EDGE_ANY), DATA_W=32.
- One sub-module, reverb_pio_edge_det:
  - Holds the synchronizer/sample stage, p register, priming flag and EDGE_TYPE select.
  - Outputs s and ev.
  - The top level holds the registers, bus decode and irq.

## Test plan
- Reset with in_port=8'hFF held high, release -> EDGECAP reads 0, DATA reads 8'hFF, irq stays 0.
- EDGE_TYPE=0, IRQMASK=8'h01, pulse in_port[0] 0->1 -> EDGECAP=8'h01 2 cycles later (3 with the macro), irq=1. Write 8'h01 to addr 3 -> irq=0 on that edge, EDGECAP=0.
- IRQMASK=0, rising edge on bit 3 -> EDGECAP=8'h08, irq stays 0. Write IRQMASK=8'h08 -> irq=1 on the write edge.
- New edge on bit 2 in the same cycle as a write-1-clear of 8'h04 -> EDGECAP[2] remains 1.
- EDGE_TYPE=2, toggle bit 5 1->0->1 with clears between -> captured both times. Read addr 1 -> 0. Read addr 0 -> readdata valid exactly one cycle after the read strobe.
- Assert reset while EDGECAP=8'hFF and irq=1 -> both 0 on the next edge. IRQMASK returns to IRQ_MASK_RESET.
